// File: rtl/modn_updown_counter_if.sv
// Control/status bundle for modn_updown_counter.
// The err signal exists only when MODN_COUNTER_ERR_DETECT_EN is defined.
interface modn_updown_counter_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             up_dn;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
`ifdef MODN_COUNTER_ERR_DETECT_EN
   logic             err;
`endif

   modport master (
      output en, clr, load, load_val, up_dn,
`ifdef MODN_COUNTER_ERR_DETECT_EN
      input  q, tc, wrap, err
`else
      input  q, tc, wrap
`endif
   );

   modport slave (
      input  en, clr, load, load_val, up_dn,
`ifdef MODN_COUNTER_ERR_DETECT_EN
      output q, tc, wrap, err
`else
      output q, tc, wrap
`endif
   );
endinterface

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with load, clear, enable and optional saturation.
// Optional sticky range-error flag via MODN_COUNTER_ERR_DETECT_EN.
module modn_updown_counter #(
   parameter int MODULUS     = 5,
   parameter int WIDTH       = 3,
   parameter int RESET_VALUE = 0,
   parameter bit SATURATE    = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   modn_updown_counter_if.slave  bus
);
   // MODULUS may equal 2**WIDTH, so only MODULUS-1 is ever held at WIDTH bits.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ZERO    = '0;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   generate
      if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
         $error("modn_updown_counter: MODULUS out of range for WIDTH");
      end
      if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
         $error("modn_updown_counter: RESET_VALUE must be below MODULUS");
      end
      if ($bits(bus.q) != WIDTH) begin : g_bad_if_width
         $error("modn_updown_counter: interface WIDTH does not match");
      end
   endgenerate

   logic [WIDTH-1:0] q_r, q_nxt;
   logic             wrap_r, wrap_nxt;
   logic             q_legal, load_legal;
   logic             at_top, at_bot;

   assign q_legal    = (q_r <= MAX_VAL);
   assign load_legal = (bus.load_val <= MAX_VAL);
   assign at_top     = (q_r == MAX_VAL);
   assign at_bot     = (q_r == ZERO);

   always_comb begin
      q_nxt    = q_r;
      wrap_nxt = 1'b0;
      if (bus.clr) begin
         q_nxt = RST_VAL;
      end else if (bus.load) begin
         q_nxt = load_legal ? bus.load_val : ZERO;
      end else if (bus.en) begin
         if (!q_legal) begin
            q_nxt = ZERO;
         end else if (bus.up_dn) begin
            if (!at_top) begin
               q_nxt = q_r + ONE;
            end else if (!SATURATE) begin
               q_nxt    = ZERO;
               wrap_nxt = 1'b1;
            end
         end else begin
            if (!at_bot) begin
               q_nxt = q_r - ONE;
            end else if (!SATURATE) begin
               q_nxt    = MAX_VAL;
               wrap_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r    <= RST_VAL;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         wrap_r <= wrap_nxt;
      end
   end

   // tc ignores clr/load so a cascade chain settles from q and en alone.
   assign bus.tc   = bus.en & ((bus.up_dn & at_top) | (~bus.up_dn & at_bot));
   assign bus.q    = q_r;
   assign bus.wrap = wrap_r;

`ifdef MODN_COUNTER_ERR_DETECT_EN
   logic err_r;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_r <= 1'b0;
      end else if (bus.clr) begin
         err_r <= 1'b0;
      end else if ((bus.load && !load_legal) || !q_legal) begin
         err_r <= 1'b1;
      end
   end

   assign bus.err = err_r;
`endif
endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: default, saturating, cascaded and power-of-two instances.
module tb_modn_updown_counter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   modn_updown_counter_if #(.WIDTH(3)) a_if ();
   modn_updown_counter_if #(.WIDTH(4)) s_if ();
   modn_updown_counter_if #(.WIDTH(4)) c0_if ();
   modn_updown_counter_if #(.WIDTH(4)) c1_if ();
   modn_updown_counter_if #(.WIDTH(3)) p_if ();

   modn_updown_counter #(.MODULUS(5), .WIDTH(3)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(a_if.slave));
   modn_updown_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(1'b1)) dut_s (
      .clk(clk), .reset_n(reset_n), .bus(s_if.slave));
   modn_updown_counter #(.MODULUS(10), .WIDTH(4)) dut_c0 (
      .clk(clk), .reset_n(reset_n), .bus(c0_if.slave));
   modn_updown_counter #(.MODULUS(10), .WIDTH(4)) dut_c1 (
      .clk(clk), .reset_n(reset_n), .bus(c1_if.slave));
   modn_updown_counter #(.MODULUS(8), .WIDTH(3)) dut_p (
      .clk(clk), .reset_n(reset_n), .bus(p_if.slave));

   assign c1_if.en = c0_if.tc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      automatic int     up_q[12];
      automatic int     dn_q[5]  = '{2, 1, 0, 4, 3};
      automatic int     dn_w[5]  = '{0, 0, 0, 1, 0};
      automatic int     sat_q[6] = '{7, 8, 9, 9, 9, 9};

      a_if.en = 0; a_if.clr = 0; a_if.load = 0; a_if.load_val = '0; a_if.up_dn = 1;
      s_if.en = 0; s_if.clr = 0; s_if.load = 0; s_if.load_val = '0; s_if.up_dn = 1;
      c0_if.en = 0; c0_if.clr = 0; c0_if.load = 0; c0_if.load_val = '0; c0_if.up_dn = 1;
      c1_if.clr = 0; c1_if.load = 0; c1_if.load_val = '0; c1_if.up_dn = 1;
      p_if.en = 0; p_if.clr = 0; p_if.load = 0; p_if.load_val = '0; p_if.up_dn = 1;
      for (int i = 0; i < 12; i++) up_q[i] = i % 5;

      #12;
      chk("reset_q", 32'(a_if.q), 0);
      chk("reset_wrap", 32'(a_if.wrap), 0);
`ifdef MODN_COUNTER_ERR_DETECT_EN
      chk("reset_err", 32'(a_if.err), 0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // up count through two wraps
      a_if.en = 1; a_if.up_dn = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         chk($sformatf("up_q[%0d]", i), 32'(a_if.q), 32'(up_q[i]));
         chk($sformatf("up_tc[%0d]", i), 32'(a_if.tc), 32'(up_q[i] == 4));
         chk($sformatf("up_wrap[%0d]", i), 32'(a_if.wrap), 32'(i > 0 && up_q[i] == 0));
         tick();
      end
      a_if.en = 0;

      // load then down count through zero
      a_if.load = 1; a_if.load_val = 3'd2;
      tick();
      a_if.load = 0; a_if.en = 1; a_if.up_dn = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("dn_q[%0d]", i), 32'(a_if.q), 32'(dn_q[i]));
         chk($sformatf("dn_tc[%0d]", i), 32'(a_if.tc), 32'(dn_q[i] == 0));
         chk($sformatf("dn_wrap[%0d]", i), 32'(a_if.wrap), 32'(dn_w[i]));
         tick();
      end
      a_if.en = 0; a_if.up_dn = 1;

      // priority clr > load > en
      a_if.load = 1; a_if.load_val = 3'd3;
      tick();
      chk("pri_load3", 32'(a_if.q), 3);
      a_if.clr = 1; a_if.load_val = 3'd1; a_if.en = 1;
      tick();
      chk("pri_clr", 32'(a_if.q), 0);
      chk("pri_clr_wrap", 32'(a_if.wrap), 0);
      a_if.clr = 0;
      tick();
      chk("pri_load_over_en", 32'(a_if.q), 1);
      a_if.en = 0;

      // out-of-range load, hold with en=0, tc independent of load
      a_if.load_val = 3'd6;
      tick();
      chk("oor_load", 32'(a_if.q), 0);
`ifdef MODN_COUNTER_ERR_DETECT_EN
      chk("oor_err_set", 32'(a_if.err), 1);
`endif
      a_if.load_val = 3'd4;
      tick();
      a_if.load = 0;
      tick();
      chk("hold_en0", 32'(a_if.q), 4);
`ifdef MODN_COUNTER_ERR_DETECT_EN
      chk("err_sticky", 32'(a_if.err), 1);
`endif
      a_if.en = 1; a_if.load = 1; a_if.load_val = 3'd0;
      #1;
      chk("tc_with_load", 32'(a_if.tc), 1);
      tick();
      chk("load_beats_wrap_q", 32'(a_if.q), 0);
      chk("load_beats_wrap_w", 32'(a_if.wrap), 0);
      a_if.en = 0; a_if.load = 0;
`ifdef MODN_COUNTER_ERR_DETECT_EN
      a_if.clr = 1;
      tick();
      chk("err_clr", 32'(a_if.err), 0);
      a_if.clr = 0;
`endif

      // asynchronous reset mid-cycle
      a_if.load = 1; a_if.load_val = 3'd3;
      tick();
      a_if.load = 0;
      chk("ar_pre", 32'(a_if.q), 3);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_q", 32'(a_if.q), 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // saturating MODULUS=10
      s_if.load = 1; s_if.load_val = 4'd7;
      tick();
      s_if.load = 0; s_if.en = 1; s_if.up_dn = 1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("sat_q[%0d]", i), 32'(s_if.q), 32'(sat_q[i]));
         chk($sformatf("sat_tc[%0d]", i), 32'(s_if.tc), 32'(sat_q[i] == 9));
         chk($sformatf("sat_wrap[%0d]", i), 32'(s_if.wrap), 0);
         tick();
      end
      s_if.en = 0; s_if.load = 1; s_if.load_val = 4'd0;
      tick();
      s_if.load = 0; s_if.en = 1; s_if.up_dn = 0;
      #1;
      chk("sat_dn_tc", 32'(s_if.tc), 1);
      tick();
      chk("sat_dn_q", 32'(s_if.q), 0);
      chk("sat_dn_wrap", 32'(s_if.wrap), 0);
      s_if.en = 0;

      // two-stage decade cascade
      c0_if.en = 1; c0_if.up_dn = 1;
      for (int i = 0; i <= 25; i++) begin
         #1;
         chk($sformatf("cas0[%0d]", i), 32'(c0_if.q), 32'(i % 10));
         chk($sformatf("cas1[%0d]", i), 32'(c1_if.q), 32'(i / 10));
         if (i < 25) tick();
      end
      c0_if.en = 0;

      // MODULUS == 2**WIDTH, back-to-back wraps
      p_if.load = 1; p_if.load_val = 3'd7;
      tick();
      p_if.load = 0; p_if.en = 1; p_if.up_dn = 1;
      tick();
      chk("pow2_up_q", 32'(p_if.q), 0);
      chk("pow2_up_wrap", 32'(p_if.wrap), 1);
      p_if.up_dn = 0;
      tick();
      chk("pow2_dn_q", 32'(p_if.q), 7);
      chk("pow2_dn_wrap", 32'(p_if.wrap), 1);
      p_if.en = 0;
      tick();
      chk("pow2_wrap_drop", 32'(p_if.wrap), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
- Parametrised synchronous modulo-N counter; successor to the fixed mod-5 counter.
- Adds:
  - configurable modulus and width
  - up/down direction
  - parallel load and synchronous clear
  - count enable, for cascading via terminal count
  - optional saturate mode
- Used as a timebase divider, sequence index and cascadable digit counter in datapath control blocks.

Parameters:
- MODULUS, 5, count range 0..MODULUS-1; legal range 2..2**WIDTH.
- WIDTH, 3, counter width in bits; must satisfy 2**WIDTH >= MODULUS.
- RESET_VALUE, 0, value q takes on reset and on clr; must be < MODULUS.
- SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at the ends of the range.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- en  input  1  count enable; a count step happens only when en=1
- clr  input  1  synchronous clear to RESET_VALUE
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value loaded when load=1
- up_dn  input  1  1 = count up, 0 = count down
- q  output  WIDTH  registered count
- tc  output  1  terminal count, combinational, for cascading into the next stage's en
- wrap  output  1  registered one-cycle pulse, set the cycle after a wrap occurs

Behaviour:
- Reset: reset_n=0 asynchronously forces q=RESET_VALUE and wrap=0 (err=0 if enabled). Reset mid-count aborts the count immediately; counting resumes on the first clk edge after reset_n rises.
- Priority at each rising clk edge, highest first: clr > load > en. The first active condition applies.
  - clr=1: q<=RESET_VALUE, wrap<=0.
  - load=1: q<=load_val if load_val<MODULUS, else q<=0. wrap<=0. Load does not require en.
  - en=1, up_dn=1:
    - q<MODULUS-1: q<=q+1.
    - q==MODULUS-1, SATURATE=0: q<=0, wrap<=1.
    - q==MODULUS-1, SATURATE=1: q holds, wrap<=0.
  - en=1, up_dn=0:
    - q>0: q<=q-1.
    - q==0, SATURATE=0: q<=MODULUS-1, wrap<=1.
    - q==0, SATURATE=1: q holds, wrap<=0.
  - Otherwise: q holds, wrap<=0.
- wrap is a single-cycle pulse. Back-to-back wraps (MODULUS=2, en held high) produce wrap high on consecutive cycles.
- tc = en & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)).
  - Purely combinational, with no dependence on clr or load.
  - Cascade rule: stage k+1 en = stage k tc, all stages on the same clk.
- Illegal state (q>=MODULUS, reachable only through upsets): the next en step forces q<=0, wrap<=0. A clr or load recovers the counter normally.
- Direction change takes effect on the same edge it is sampled; there is no turnaround penalty.
- Latency:
  - q updates one clk after the control inputs are sampled.
  - tc is valid in the same cycle as q and en.
  - wrap appears one cycle after the wrapping edge, coincident with the new q.
- Arithmetic: all compares are done at WIDTH bits. Wrap values are derived from MODULUS, never from 2**WIDTH overflow. When MODULUS==2**WIDTH, behaviour matches natural binary wrap.

Optional Feature:
- Macro: MODN_COUNTER_ERR_DETECT_EN
- Defined:
  - Adds output err (1 bit, registered, reset 0).
  - err sets on the clk edge where load=1 with load_val>=MODULUS, or where q>=MODULUS is observed.
  - err is sticky until clr=1 or reset.
  - Counting behaviour is unchanged.
- Undefined: the err port and its logic are absent. Out-of-range loads and illegal states are silently handled as described in Behaviour.

Test Plan:
- Defaults (MODULUS=5, WIDTH=3), release reset, en=1, up_dn=1 for 12 cycles -> q sequence 0,1,2,3,4,0,1,2,3,4,0,1; wrap high the cycle q returns to 0; tc high while q==4.
- Down count: load=1, load_val=2, then en=1, up_dn=0 for 4 cycles -> q 2,1,0,4,3; tc high while q==0; wrap pulses once when q==4.
- Priority: q=3 with clr=1, load=1, load_val=1, en=1 -> q=0; then load=1, en=1, load_val=1 -> q=1 (load beats count).
- SATURATE=1, MODULUS=10, WIDTH=4: up-count from 7 for 5 cycles -> q 8,9,9,9,9; wrap never asserts; tc stays 1 while q==9, en=1.
- Cascade: two instances, MODULUS=10, with stage1 en = stage0 tc; count up 25 cycles from 0 -> stage1 q=2, stage0 q=5; stage1 increments only on the cycles stage0 goes 9->0.
- Async reset: assert reset_n=0 mid-cycle while q=3 -> q=0 immediately without a clk edge. With MODN_COUNTER_ERR_DETECT_EN: load_val=6 at MODULUS=5 -> q=0, err=1, err held until clr.
